// File: rtl/cart_header_loader.sv
// Boot sequencer: fetches and validates the cartridge header, holds the mapper in reset until done.
// Optional macro CART_CHECKSUM_EN: read the full 0x134..0x14D range and verify the header checksum.
module cart_header_loader #(
    parameter logic [20:0] ROM_BASE = 21'h000000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic [20:0] mem_adr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        done,
    output logic        hdr_ok,
    output logic [7:0]  cart_type,
    output logic [2:0]  rom_size,
    output logic [1:0]  ram_size,
    output logic        mbc_reset
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

`ifdef CART_CHECKSUM_EN
    localparam logic [8:0] FIRST_OFF = 9'h134;
    localparam logic [8:0] LAST_OFF  = 9'h14D;
`else
    localparam logic [8:0] FIRST_OFF = 9'h147;
    localparam logic [8:0] LAST_OFF  = 9'h149;
`endif

    logic [2:0]  r_state;
    logic [8:0]  r_off;
    logic        r_mem_rd;
    logic [15:0] r_wcnt;
    logic        r_done;
    logic        r_hdr_ok;
    logic [7:0]  r_cart_type;
    logic [2:0]  r_rom_size;
    logic [1:0]  r_ram_size;
    logic        r_range_err;
    logic        w_sum_ok;
    logic        w_timeout;

`ifdef CART_CHECKSUM_EN
    logic [7:0]  r_acc;
    logic [7:0]  r_exp;
    assign w_sum_ok = (r_acc == r_exp);
`else
    assign w_sum_ok = 1'b1;
`endif

    assign w_timeout = (TIMEOUT > 0) && (r_wcnt == 16'(TIMEOUT - 1));

    assign mem_adr   = ROM_BASE + {12'd0, r_off};
    assign mem_rd    = r_mem_rd;
    assign done      = r_done;
    assign hdr_ok    = r_hdr_ok;
    assign cart_type = r_cart_type;
    assign rom_size  = r_rom_size;
    assign ram_size  = r_ram_size;
    assign mbc_reset = !r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_off       <= 9'h134;
            r_mem_rd    <= 1'b0;
            r_wcnt      <= 16'd0;
            r_done      <= 1'b0;
            r_hdr_ok    <= 1'b0;
            r_cart_type <= 8'd0;
            r_rom_size  <= 3'd0;
            r_ram_size  <= 2'd0;
            r_range_err <= 1'b0;
`ifdef CART_CHECKSUM_EN
            r_acc       <= 8'd0;
            r_exp       <= 8'd0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_off   <= FIRST_OFF;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    r_mem_rd <= 1'b1;
                    r_wcnt   <= 16'd0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_mem_rd <= 1'b0;
                        if (r_off == 9'h147)
                            r_cart_type <= mem_data;
                        if (r_off == 9'h148) begin
                            if (mem_data <= 8'd6) begin
                                r_rom_size <= mem_data[2:0];
                            end else begin
                                r_rom_size  <= 3'd0;
                                r_range_err <= 1'b1;
                            end
                        end
                        if (r_off == 9'h149) begin
                            if (mem_data <= 8'd3) begin
                                r_ram_size <= mem_data[1:0];
                            end else begin
                                r_ram_size  <= 2'd0;
                                r_range_err <= 1'b1;
                            end
                        end
`ifdef CART_CHECKSUM_EN
                        // last byte is the reference, all earlier ones feed the sum
                        if (r_off == LAST_OFF)
                            r_exp <= mem_data;
                        else
                            r_acc <= r_acc - mem_data - 8'd1;
`endif
                        if (r_off == LAST_OFF) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_off   <= r_off + 9'd1;
                            r_state <= S_REQ;
                        end
                    end else if (w_timeout) begin
                        r_mem_rd <= 1'b0;
                        r_done   <= 1'b1;
                        r_hdr_ok <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_wcnt <= r_wcnt + 16'd1;
                    end
                end
                S_CHECK: begin
                    r_hdr_ok <= w_sum_ok && !r_range_err;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_mem_rd <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_header_loader.sv
// Bench for cart_header_loader: directed and randomized headers against a header reference model.
module tb_cart_header_loader;

    localparam logic [20:0] BASE = 21'h1FFF00;
    localparam int TMO = 255;
    localparam int BUDGET = 5000;
`ifdef CART_CHECKSUM_EN
    localparam int NREADS = 26;
    localparam int FIRST = 'h134;
`else
    localparam int NREADS = 3;
    localparam int FIRST = 'h147;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [20:0] mem_adr;
    logic        mem_rd;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'd0;
    logic        done;
    logic        hdr_ok;
    logic [7:0]  cart_type;
    logic [2:0]  rom_size;
    logic [1:0]  ram_size;
    logic        mbc_reset;

    int checks = 0;
    int errors = 0;
    logic [7:0] hdr [0:25];
    logic [20:0] adr_log [$];
    int rd_high;

    cart_header_loader #(.ROM_BASE(BASE), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .mem_adr(mem_adr), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .done(done), .hdr_ok(hdr_ok),
        .cart_type(cart_type), .rom_size(rom_size),
        .ram_size(ram_size), .mbc_reset(mbc_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] addr_of(input int off);
        return 21'(BASE + 21'(off));
    endfunction

    // Reference: header-level rules evaluated directly on the byte image.
    task automatic check_result(input string tag);
        int sum;
        logic [7:0] acc;
        bit rng;
        bit ok;
        sum = 0;
        for (int i = 0; i < 25; i++) sum += int'(hdr[i]);
        acc = 8'(-(sum + 25));
        rng = (hdr[20] > 8'd6) || (hdr[21] > 8'd3);
`ifdef CART_CHECKSUM_EN
        ok = (acc == hdr[25]) && !rng;
`else
        ok = !rng;
`endif
        chk({tag, "_nreads"}, adr_log.size(), NREADS);
        for (int i = 0; i < NREADS && i < adr_log.size(); i++)
            chk({tag, "_adr"}, adr_log[i], addr_of(FIRST + i));
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_mbcrst"}, mbc_reset, 1'b0);
        chk({tag, "_hdr_ok"}, hdr_ok, ok);
        chk({tag, "_cart"}, cart_type, hdr[19]);
        chk({tag, "_rom"}, rom_size, (hdr[20] <= 8'd6) ? hdr[20][2:0] : 3'd0);
        chk({tag, "_ram"}, ram_size, (hdr[21] <= 8'd3) ? hdr[21][1:0] : 2'd0);
    endtask

    task automatic run_load(input int dmin, input int dmax, input bit spur,
                            input bit noack, input int stop_read);
        int cyc = 0;
        int wcnt = 0;
        int dly = 0;
        int idx;
        bit prev_rd = 0;
        bit acked = 0;
        adr_log.delete();
        rd_high = 0;
        while (!done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            chk("mbc_vs_done", mbc_reset, !done);
            if (acked) begin
                chk("rd_gap", mem_rd, 1'b0);
                acked = 0;
            end
            if (mem_rd) begin
                rd_high++;
                if (!prev_rd) begin
                    adr_log.push_back(mem_adr);
                    wcnt = 0;
                    dly = $urandom_range(dmax, dmin);
                    if (stop_read == adr_log.size() - 1) begin
                        mem_ack = 1'b0;
                        return;
                    end
                end
                idx = int'(21'(mem_adr - BASE)) - 'h134;
                if (!noack && wcnt == dly && idx >= 0 && idx < 26) begin
                    mem_ack = 1'b1;
                    mem_data = hdr[idx];
                    acked = 1;
                end else begin
                    mem_ack = 1'b0;
                    mem_data = 8'($urandom);
                end
                wcnt++;
            end else begin
                mem_ack = spur ? 1'($urandom_range(1, 0)) : 1'b0;
                mem_data = 8'($urandom);
            end
            prev_rd = mem_rd;
        end
        mem_ack = 1'b0;
        if (stop_read < 0 && !done) chk("load_budget", done, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic base_header();
        for (int i = 0; i < 26; i++) hdr[i] = 8'h00;
        hdr[19] = 8'h01;
        hdr[20] = 8'h02;
        hdr[21] = 8'h03;
        hdr[25] = 8'hE1;
    endtask

    initial begin
        int sum;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_adr", mem_adr, addr_of('h134));
        chk("rst_done", done, 1'b0);
        chk("rst_hdr_ok", hdr_ok, 1'b0);
        chk("rst_cart", cart_type, 8'd0);
        chk("rst_rom", rom_size, 3'd0);
        chk("rst_ram", ram_size, 2'd0);
        chk("rst_mbc", mbc_reset, 1'b1);
        reset = 1'b0;

        base_header();
        run_load(1, 1, 0, 0, -1);
        check_result("good");

        do_reset();
        base_header();
        hdr[25] = 8'hE2;
        run_load(1, 1, 0, 0, -1);
        check_result("badsum");

        do_reset();
        base_header();
        hdr[20] = 8'h07;
        hdr[25] = 8'hDC;
        run_load(0, 0, 0, 0, -1);
        check_result("badrom");

        do_reset();
        base_header();
        run_load(0, 20, 1, 0, -1);
        check_result("rnd_delay");

        for (int t = 0; t < 6; t++) begin
            do_reset();
            for (int i = 0; i < 26; i++) hdr[i] = 8'($urandom);
            hdr[20] = 8'($urandom_range(8, 0));
            hdr[21] = 8'($urandom_range(5, 0));
            if ($urandom_range(1, 0) == 1) begin
                sum = 0;
                for (int i = 0; i < 25; i++) sum += int'(hdr[i]);
                hdr[25] = 8'(-(sum + 25));
            end
            run_load(0, 20, 1, 0, -1);
            check_result("rnd_hdr");
        end

        do_reset();
        base_header();
        run_load(0, 0, 0, 1, -1);
        chk("tmo_cycles", rd_high, TMO);
        chk("tmo_nreads", adr_log.size(), 1);
        chk("tmo_adr", mem_adr, addr_of(FIRST));
        chk("tmo_done", done, 1'b1);
        chk("tmo_hdr_ok", hdr_ok, 1'b0);
        chk("tmo_cart", cart_type, 8'd0);
        chk("tmo_rom", rom_size, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("tmo_rd_low", mem_rd, 1'b0);
        end

        do_reset();
        base_header();
        run_load(0, 2, 0, 0, (NREADS > 10) ? 10 : 1);
        @(negedge clk);
        chk("mid_waiting", mem_rd, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rd", mem_rd, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_mbc", mbc_reset, 1'b1);
        chk("mid_adr", mem_adr, addr_of('h134));
        reset = 1'b0;
        run_load(0, 3, 1, 0, -1);
        check_result("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
